// File: rtl/alu4_operand_sequencer.sv
// rtl/alu4_operand_sequencer.sv - registered operand/result stage around the 4-bit logic units and adder
// Accepts an operand pair, drives x/y, waits SETTLE_CYCLES, captures the selected unit output.
module alu4_operand_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int COUNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_a,
   input  logic [3:0]         in_b,
   input  logic [1:0]         in_op,
   output logic [3:0]         x,
   output logic [3:0]         y,
   input  logic [3:0]         and_o,
   input  logic [3:0]         or_o,
   input  logic [3:0]         xor_o,
   input  logic [3:0]         sum_o,
   input  logic               sum_c,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_res,
   output logic               out_carry,
   output logic               out_zero,
   output logic [COUNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] settle_cnt;
   logic [1:0] op_r;
   logic       accept;
   logic       capture;
   logic       handoff;
   logic [3:0] res_sel;
   logic       carry_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)  state_next = SETTLE;
         SETTLE:  if (capture) state_next = HOLD;
         HOLD:    if (handoff) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decode the registered state only.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == HOLD);
      accept    = in_valid && in_ready;
      capture   = (state == SETTLE) && (settle_cnt == 4'd0);
      handoff   = out_valid && out_ready;
   end

   always_comb begin
      res_sel   = sum_o;
      carry_sel = sum_c;
      case (op_r)
         OP_AND:  begin res_sel = and_o; carry_sel = 1'b0; end
         OP_OR:   begin res_sel = or_o;  carry_sel = 1'b0; end
         OP_XOR:  begin res_sel = xor_o; carry_sel = 1'b0; end
         default: begin res_sel = sum_o; carry_sel = sum_c; end
      endcase
   end

   // x/y keep the last operands until the next acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         x          <= 4'd0;
         y          <= 4'd0;
         op_r       <= OP_AND;
         settle_cnt <= 4'd0;
         out_res    <= 4'd0;
         out_carry  <= 1'b0;
         out_zero   <= 1'b0;
         op_count   <= '0;
      end else begin
         if (accept) begin
            x          <= in_a;
            y          <= in_b;
            op_r       <= in_op;
            settle_cnt <= SETTLE_INIT;
         end else if (state == SETTLE && !capture) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         if (capture) begin
            out_res   <= res_sel;
            out_carry <= carry_sel;
            out_zero  <= (res_sel == 4'd0);
         end
         if (handoff) begin
            op_count <= op_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu4_operand_sequencer.sv
// tb/tb_alu4_operand_sequencer.sv - directed self-checking bench for alu4_operand_sequencer
// Bit-level unit models are attached to x/y; expectations come from a reference function on the operands.
module tb_alu4_operand_sequencer;

   localparam int SETTLE = 2;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [1:0] in_op;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] and_o;
   logic [3:0] or_o;
   logic [3:0] xor_o;
   logic [3:0] sum_o;
   logic       sum_c;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_res;
   logic       out_carry;
   logic       out_zero;
   logic [7:0] op_count;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic [7:0] prev_cnt = 8'd0;
   logic       wrap_seen = 1'b0;

   alu4_operand_sequencer #(.SETTLE_CYCLES(SETTLE), .COUNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .x(x), .y(y),
      .and_o(and_o), .or_o(or_o), .xor_o(xor_o), .sum_o(sum_o), .sum_c(sum_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_carry(out_carry), .out_zero(out_zero),
      .op_count(op_count)
   );

   assign and_o = x & y;
   assign or_o  = x | y;
   assign xor_o = x ^ y;
   assign {sum_c, sum_o} = {1'b0, x} + {1'b0, y};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      case (op)
         2'b00:   ref_res = {1'b0, a & b};
         2'b01:   ref_res = {1'b0, a | b};
         2'b10:   ref_res = {1'b0, a ^ b};
         default: ref_res = {1'b0, a} + {1'b0, b};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic accept_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_op = op;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = ~a;
      in_b = ~b;
      in_op = ~op;
      chk("x_drive", 32'(x), 32'(a));
      chk("y_drive", 32'(y), 32'(b));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_result(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int lat = 0;
      logic [4:0] e;
      e = ref_res(a, b, op);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(SETTLE));
      chk("out_res", 32'(out_res), 32'(e[3:0]));
      chk("out_carry", 32'(out_carry), 32'(e[4]));
      chk("out_zero", 32'(out_zero), 32'(e[3:0] == 4'd0));
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      chk("handoff_valid", 32'(out_valid), 32'd0);
      chk("handoff_ready", 32'(in_ready), 32'd1);
      chk("op_count", 32'(op_count), 32'(exp_cnt));
      if (prev_cnt == 8'hFF && op_count == 8'h00) wrap_seen = 1'b1;
      prev_cnt = op_count;
   endtask

   initial begin
      logic [3:0] held;
      reset = 1'b1;
      in_valid = 1'b0;
      in_a = 4'd0;
      in_b = 4'd0;
      in_op = 2'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_res", 32'({out_res, out_carry, out_zero}), 32'd0);
      chk("rst_count", 32'(op_count), 32'd0);

      // Reset one cycle into SETTLE drops the OR operation.
      accept_op(4'b0101, 4'b0011, 2'b01);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_x", 32'(x), 32'd0);
      chk("midrst_y", 32'(y), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_count", 32'(op_count), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_no_pulse", 32'(out_valid), 32'd0);
      end

      accept_op(4'b1100, 4'b1010, 2'b00);
      wait_result(4'b1100, 4'b1010, 2'b00);
      chk("and_res", 32'(out_res), 32'b1000);
      handoff();

      accept_op(4'b1001, 4'b1000, 2'b11);
      wait_result(4'b1001, 4'b1000, 2'b11);
      chk("add_res", 32'({out_carry, out_res}), 32'b10001);
      handoff();

      accept_op(4'b1111, 4'b1111, 2'b10);
      wait_result(4'b1111, 4'b1111, 2'b10);
      chk("xor_zero", 32'({out_carry, out_zero, out_res}), 32'b010000);
      handoff();

      // Backpressure: a waiting upstream pair must not be taken.
      accept_op(4'b0110, 4'b0111, 2'b11);
      wait_result(4'b0110, 4'b0111, 2'b11);
      held = out_res;
      in_valid = 1'b1;
      in_a = 4'b0001;
      in_b = 4'b0001;
      in_op = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_res", 32'(out_res), 32'(held));
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_count", 32'(op_count), 32'(exp_cnt));
         chk("bp_x", 32'(x), 32'b0110);
      end
      in_valid = 1'b0;
      handoff();

      // Simultaneous hand-off and new pair: accepted one edge later.
      accept_op(4'b0101, 4'b0011, 2'b01);
      wait_result(4'b0101, 4'b0011, 2'b01);
      in_valid = 1'b1;
      in_a = 4'b1001;
      in_b = 4'b0110;
      in_op = 2'b11;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      chk("sim_valid", 32'(out_valid), 32'd0);
      chk("sim_ready", 32'(in_ready), 32'd1);
      chk("sim_not_taken", 32'(x), 32'b0101);
      chk("sim_count", 32'(op_count), 32'(exp_cnt));
      @(negedge clk);
      in_valid = 1'b0;
      chk("sim_taken_x", 32'(x), 32'b1001);
      chk("sim_taken_y", 32'(y), 32'b0110);
      chk("sim_busy", 32'(in_ready), 32'd0);
      wait_result(4'b1001, 4'b0110, 2'b11);
      handoff();
      prev_cnt = op_count;

      for (int op = 0; op < 4; op++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               accept_op(4'(a), 4'(b), 2'(op));
               wait_result(4'(a), 4'(b), 2'(op));
               handoff();
            end
         end
      end
      chk("count_wrapped", 32'(wrap_seen), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu4_operand_sequencer.md
Name: alu4_operand_sequencer

Overview:
- Registered front/back end for the 4-bit bitwise units (andBitwise / orBitwise / xorBitwise) and the 4-bit adder.
- Accepts an operand pair plus opcode over a valid/ready handshake and drives the units' x/y inputs from registers.
- Waits a programmable settle time, then captures the selected unit's o0..o3 (and carry) into an output register.
- Presents the result downstream with its own valid/ready handshake. Replaces the exhaustive-loop stimulus with a real clocked stage.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving x/y and capturing unit outputs; legal range is 1..15.
- COUNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an operand pair.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  4  operand A; bit i maps to xi.
- in_b  in  4  operand B; bit i maps to yi.
- in_op  in  2  00 AND, 01 OR, 10 XOR, 11 ADD.
- x  out  4  registered drive to unit inputs x3..x0.
- y  out  4  registered drive to unit inputs y3..y0.
- and_o  in  4  andBitwise o3..o0.
- or_o  in  4  orBitwise o3..o0.
- xor_o  in  4  xorBitwise o3..o0.
- sum_o  in  4  adder sum.
- sum_c  in  1  adder carry out.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result.
- out_res  out  4  captured result.
- out_carry  out  1  captured carry; 0 for logic ops.
- out_zero  out  1  1 when out_res == 0.
- op_count  out  COUNT_W  completed (handed-off) operations.

Behaviour:
- Reset, when sampled high at a rising edge:
  - State goes to IDLE; x, y, out_res, out_carry, out_zero and op_count go to 0.
  - out_valid goes to 0 and in_ready to 1.
  - Reset overrides every other event on the same edge.
- FSM states are IDLE, SETTLE and HOLD.
  - in_ready = 1 only in IDLE. It is a registered-state decode, not combinational on in_valid.
- IDLE:
  - Acceptance occurs on an edge where in_valid & in_ready.
  - At that edge: x <= in_a, y <= in_b, op_r <= in_op, settle counter <= SETTLE_CYCLES-1, state goes to SETTLE.
  - in_a, in_b and in_op are don't-care after acceptance.
- SETTLE:
  - The counter decrements each edge.
  - On the edge where the counter is 0, capture per op_r:
    - AND: and_o. OR: or_o. XOR: xor_o. ADD: sum_o, with out_carry <= sum_c.
    - For logic ops, out_carry <= 0.
    - out_zero <= (selected result == 0); out_valid <= 1; state goes to HOLD.
  - Latency: acceptance at edge N gives out_valid high after edge N+SETTLE_CYCLES.
- HOLD:
  - out_res, out_carry and out_zero are stable while out_valid=1.
  - On an edge with out_valid & out_ready: out_valid <= 0, op_count <= op_count+1, state goes to IDLE.
  - If out_ready stays low, the block holds indefinitely. There is no data loss and no overwrite.
- x/y retain the last operands after capture and through IDLE until the next acceptance; they never glitch to 0.
- Unit inputs (and_o etc.) are sampled only on the capture edge. Changes at other times are ignored.
- A simultaneous out_ready and in_valid in HOLD does not accept the new pair, because in_ready=0.
  - The new pair is accepted no earlier than the edge after the hand-off.
  - Peak throughput is one operation per SETTLE_CYCLES+2 cycles.
- op_count wraps modulo 2^COUNT_W (8'hFF -> 8'h00) and is cleared only by reset.
- Reset during SETTLE or HOLD drops the pending operation: no out_valid pulse and no count increment.

Test Plan:
- AND 1100 & 1010 with SETTLE_CYCLES=2, unit models attached:
  - Accept at edge N -> x=1100, y=1010 after N; out_valid=1 after N+2.
  - Result: out_res=1000, out_carry=0, out_zero=0.
- ADD 1001+1000 -> out_res=0001, out_carry=1. XOR 1111^1111 -> out_res=0000, out_zero=1, out_carry=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_res stable, in_ready=0, op_count unchanged.
  - Then out_ready=1 for one cycle -> out_valid=0, op_count+1, in_ready=1 next cycle.
- Simultaneous: in_valid=1 throughout HOLD, out_ready asserted.
  - Required: the new pair is not accepted on the hand-off edge; it is accepted on the following edge.
- Reset asserted mid-SETTLE (one cycle after accepting OR 0101|0011).
  - Required: after that edge out_valid=0, x=y=0, in_ready=1, op_count unchanged, no later result pulse.
- Counter wrap: complete 256 back-to-back ops with out_ready tied 1 -> op_count reads 0 and stepped 0xFF->0x00. Also cover all 16x16 operand pairs per op against a reference model.
